// File: rtl/side_buf_ctrl_nch.sv
// Side-buffer controller for an N-channel bufferless router stage.
// Deflected flits are ejected into a small FIFO and re-injected into idle slots; a forced swap breaks starvation.
module side_buf_ctrl_nch #(
    parameter int unsigned NUM_CHNL = 4,
    parameter int unsigned FLIT_W   = 64,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned REDIR_TH = 8
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [NUM_CHNL*FLIT_W-1:0]   din,
    output logic [NUM_CHNL*FLIT_W-1:0]   dout,
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic                         full,
    output logic                         empty,
    output logic                         eject_fire,
    output logic                         inject_fire,
    output logic                         redirect_fire,
    output logic [NUM_CHNL-1:0]          op_chnl
);

    localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CH_W   = $clog2(NUM_CHNL);
    localparam int unsigned CNT_W  = $clog2(REDIR_TH + 1);
    localparam int unsigned DEFL_B = FLIT_W - 1;
    localparam int unsigned VLD_B  = FLIT_W - 2;
    localparam logic [CNT_W-1:0] TH_C  = CNT_W'(REDIR_TH);
    localparam logic [CNT_W-1:0] TH_M1 = CNT_W'(REDIR_TH - 1);

    typedef enum logic [1:0] {ST_NORMAL, ST_STARVE, ST_REDIRECT} state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [CH_W-1:0]            rr_q, rr_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]           occ_q, occ_d;
    logic [FLIT_W-1:0]          mem_q [DEPTH];
    logic [FLIT_W-1:0]          mem_d [DEPTH];
    logic [NUM_CHNL*FLIT_W-1:0] dout_q, dout_d;
    logic                       ej_q, ej_d, inj_q, inj_d, rd_q, rd_d;
    logic [NUM_CHNL-1:0]        op_q, op_d;

    logic [FLIT_W-1:0]          chin [NUM_CHNL];
    logic [NUM_CHNL-1:0]        vld, defl, hole;
    logic [CH_W-1:0]            inj_idx, ej_idx, rd_idx;
    logic [FLIT_W-1:0]          fill_flit, push_flit;
    logic                       do_redir, do_inj, do_ej, push, pop, starved;

    // First requester at or after 'start', wrapping modulo NUM_CHNL.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CHNL-1:0] req,
                                                input logic [CH_W-1:0] start);
        logic [CH_W-1:0] pick;
        logic            hit;
        int unsigned     idx;
        pick = start;
        hit  = 1'b0;
        for (int unsigned i = 0; i < NUM_CHNL; i++) begin
            idx = (32'(start) + i) % NUM_CHNL;
            if (!hit && req[CH_W'(idx)]) begin
                pick = CH_W'(idx);
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] cur);
        return CH_W'((32'(cur) + 32'd1) % NUM_CHNL);
    endfunction

    assign full  = (occ_q == OCC_W'(DEPTH));
    assign empty = (occ_q == '0);

    always_comb begin
        for (int unsigned c = 0; c < NUM_CHNL; c++) begin
            chin[c] = din[c*FLIT_W +: FLIT_W];
            vld[c]  = chin[c][VLD_B];
            defl[c] = chin[c][VLD_B] & chin[c][DEFL_B];
        end
        hole = ~vld;

        inj_idx = rr_pick(hole, '0);
        ej_idx  = rr_pick(defl, rr_q);
        rd_idx  = rr_pick(vld, rr_q);

        fill_flit         = mem_q[rd_ptr_q];
        fill_flit[DEFL_B] = 1'b0;
        fill_flit[VLD_B]  = 1'b1;

        // A redirect cycle with no valid channel degrades to a plain inject.
        do_redir = (state_q == ST_REDIRECT) && (|vld);
        do_inj   = !do_redir && !empty && (|hole);
        do_ej    = !do_redir && !do_inj && !full && (|defl);

        dout_d    = din;
        push      = 1'b0;
        pop       = 1'b0;
        push_flit = '0;
        op_d      = '0;
        rr_d      = rr_q;
        ej_d      = do_ej;
        inj_d     = do_inj;
        rd_d      = do_redir;

        if (do_redir) begin
            dout_d[rd_idx*FLIT_W +: FLIT_W] = fill_flit;
            push_flit   = chin[rd_idx];
            push        = 1'b1;
            pop         = 1'b1;
            rr_d        = rr_next(rd_idx);
            op_d[rd_idx] = 1'b1;
        end else if (do_inj) begin
            dout_d[inj_idx*FLIT_W +: FLIT_W] = fill_flit;
            pop           = 1'b1;
            op_d[inj_idx] = 1'b1;
        end else if (do_ej) begin
            dout_d[ej_idx*FLIT_W +: FLIT_W] = '0;
            push_flit    = chin[ej_idx];
            push         = 1'b1;
            rr_d         = rr_next(ej_idx);
            op_d[ej_idx] = 1'b1;
        end
        push_flit[DEFL_B] = 1'b0;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_flit;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // Counter holds the number of consecutive full-and-starved cycles including this one.
        starved = full && !(|hole);
        state_d = ST_NORMAL;
        cnt_d   = '0;
        if (full) begin
            case (state_q)
                ST_NORMAL, ST_STARVE: begin
                    if (starved) begin
                        cnt_d   = (cnt_q == TH_C) ? cnt_q : cnt_q + CNT_W'(1);
                        state_d = (cnt_d >= TH_M1) ? ST_REDIRECT : ST_STARVE;
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_NORMAL;
            cnt_q    <= '0;
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            dout_q   <= '0;
            ej_q     <= 1'b0;
            inj_q    <= 1'b0;
            rd_q     <= 1'b0;
            op_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            dout_q   <= dout_d;
            ej_q     <= ej_d;
            inj_q    <= inj_d;
            rd_q     <= rd_d;
            op_q     <= op_d;
            mem_q    <= mem_d;
        end
    end

    assign dout          = dout_q;
    assign occ           = occ_q;
    assign eject_fire    = ej_q;
    assign inject_fire   = inj_q;
    assign redirect_fire = rd_q;
    assign op_chnl       = op_q;

endmodule

// File: tb/tb_side_buf_ctrl_nch.sv
// Bench for side_buf_ctrl_nch: vector table for eject/inject/full/redirect, hand sequences for
// async reset, and a payload scoreboard across FIFO pointer wrap.
module tb_side_buf_ctrl_nch;

    localparam int unsigned NCH = 4;
    localparam int unsigned FW  = 64;
    localparam int unsigned DEP = 4;
    localparam int unsigned TH  = 8;

    logic           clk = 1'b0;
    logic           n_rst;
    logic [255:0]   din;
    logic [255:0]   dout;
    logic [2:0]     occ;
    logic           full, empty, eject_fire, inject_fire, redirect_fire;
    logic [3:0]     op_chnl;

    side_buf_ctrl_nch #(
        .NUM_CHNL (NCH),
        .FLIT_W   (FW),
        .DEPTH    (DEP),
        .REDIR_TH (TH)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .din           (din),
        .dout          (dout),
        .occ           (occ),
        .full          (full),
        .empty         (empty),
        .eject_fire    (eject_fire),
        .inject_fire   (inject_fire),
        .redirect_fire (redirect_fire),
        .op_chnl       (op_chnl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] din;
        logic [255:0] dout;
        logic [2:0]   occ;
        logic         ej;
        logic         inj;
        logic         rd;
        logic [3:0]   op;
    } vec_t;

    vec_t          vecs[$];
    int unsigned   sb[$];
    int            total = 0;
    int            bad   = 0;

    function automatic logic [63:0] fp(input int unsigned x);
        return {2'b01, 62'(x)};
    endfunction

    function automatic logic [63:0] fd(input int unsigned x);
        return {2'b11, 62'(x)};
    endfunction

    function automatic logic [11:0] stat_exp(input logic [2:0] o, input logic ej, input logic inj,
                                             input logic rd, input logic [3:0] op);
        return {o, (o == 3'd4), (o == 3'd0), ej, inj, rd, op};
    endfunction

    function automatic logic [11:0] stat_act();
        return {occ, full, empty, eject_fire, inject_fire, redirect_fire, op_chnl};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic [255:0] d);
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [255:0] d, input logic [255:0] q, input logic [2:0] o,
                       input logic ej, input logic inj, input logic rd, input logic [3:0] op);
        vec_t v;
        v.din = d; v.dout = q; v.occ = o; v.ej = ej; v.inj = inj; v.rd = rd; v.op = op;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int unsigned exp_occ;
        int unsigned front;

        n_rst = 1'b0;
        din   = {fd(1), fd(2), fd(3), fd(4)};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", dout, '0);
        chk("reset_stat", 256'(stat_act()), 256'(stat_exp(3'd0, 0, 0, 0, 4'b0000)));
        n_rst = 1'b1;

        // Eject round-robin, inject priority, fill to full
        add({fd('h13), fp(2), fd('h11), fp(1)}, {fd('h13), fp(2), 64'd0, fp(1)}, 3'd1, 1, 0, 0, 4'b0010);
        add({fd('h13), fp(2), fd('h11), fp(1)}, {64'd0, fp(2), fd('h11), fp(1)}, 3'd2, 1, 0, 0, 4'b1000);
        add({fp(4), 64'd0, fp(3), fd('h20)}, {fp(4), fp('h11), fp(3), fd('h20)}, 3'd1, 0, 1, 0, 4'b0100);
        add({fp(7), fp(6), fp(5), fd('h30)}, {fp(7), fp(6), fp(5), 64'd0}, 3'd2, 1, 0, 0, 4'b0001);
        add({fp('h37), fd('h32), fp('h35), fd('h31)}, {fp('h37), 64'd0, fp('h35), fd('h31)}, 3'd3, 1, 0, 0, 4'b0100);
        add({fp('h43), fp('h42), fp('h41), fd('h33)}, {fp('h43), fp('h42), fp('h41), 64'd0}, 3'd4, 1, 0, 0, 4'b0001);
        // Full: deflected ch0 passes through; starved cycles 1..7
        add({fp(10), fp(9), fp(8), fd('h40)}, {fp(10), fp(9), fp(8), fd('h40)}, 3'd4, 0, 0, 0, 4'b0000);
        for (int i = 0; i < 6; i++)
            add({fp('h53), fp('h52), fp('h51), fp('h50)}, {fp('h53), fp('h52), fp('h51), fp('h50)},
                3'd4, 0, 0, 0, 4'b0000);
        // 8th starved cycle: head 0x13 onto rr channel ch1
        add({fp('h63), fp('h62), fd('h61), fp('h60)}, {fp('h63), fp('h62), fp('h13), fp('h60)}, 3'd4, 0, 0, 1, 4'b0010);
        // Counter restarted: seven quiet cycles, redirect on the eighth
        for (int i = 0; i < 7; i++)
            add({fp('h83), fd('h82), fp('h81), fp('h80)}, {fp('h83), fd('h82), fp('h81), fp('h80)},
                3'd4, 0, 0, 0, 4'b0000);
        add({fp('h73), fd('h72), fp('h71), fp('h70)}, {fp('h73), fp('h30), fp('h71), fp('h70)}, 3'd4, 0, 0, 1, 4'b0100);
        // Drain: redirected flits appear at the tail with deflect cleared
        add('0, {192'd0, fp('h32)}, 3'd3, 0, 1, 0, 4'b0001);
        add('0, {192'd0, fp('h33)}, 3'd2, 0, 1, 0, 4'b0001);
        add('0, {192'd0, fp('h61)}, 3'd1, 0, 1, 0, 4'b0001);
        add('0, {192'd0, fp('h72)}, 3'd0, 0, 1, 0, 4'b0001);
        add('0, '0, 3'd0, 0, 0, 0, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].din);
            chk($sformatf("vec%0d_dout", i), dout, vecs[i].dout);
            chk($sformatf("vec%0d_stat", i), 256'(stat_act()),
                256'(stat_exp(vecs[i].occ, vecs[i].ej, vecs[i].inj, vecs[i].rd, vecs[i].op)));
        end

        // Asynchronous reset with three flits buffered
        for (int i = 0; i < 3; i++) begin
            step({fp(1), fp(2), fp(3), fd('hA0 + i)});
            chk($sformatf("prerst_stat%0d", i), 256'(stat_act()),
                256'(stat_exp(3'(i + 1), 1, 0, 0, 4'b0001)));
        end
        #3 n_rst = 1'b0;
        #1;
        chk("async_rst_dout", dout, '0);
        chk("async_rst_stat", 256'(stat_act()), 256'(stat_exp(3'd0, 0, 0, 0, 4'b0000)));
        @(posedge clk);
        #1;
        chk("held_rst_stat", 256'(stat_act()), 256'(stat_exp(3'd0, 0, 0, 0, 4'b0000)));
        n_rst = 1'b1;
        step('0);
        chk("postrst_dout", dout, '0);
        chk("postrst_stat", 256'(stat_act()), 256'(stat_exp(3'd0, 0, 0, 0, 4'b0000)));

        // Scoreboard over 3*DEPTH pushes to exercise pointer wrap
        exp_occ = 0;
        for (int i = 0; i < 3 * DEP; i++) begin
            step({fp(1), fp(2), fp(3), fd('h100 + i)});
            sb.push_back('h100 + i);
            exp_occ++;
            chk($sformatf("wrap_ej%0d_dout", i), dout, {fp(1), fp(2), fp(3), 64'd0});
            chk($sformatf("wrap_ej%0d_stat", i), 256'(stat_act()),
                256'(stat_exp(3'(exp_occ), 1, 0, 0, 4'b0001)));
            if (i > 0) begin
                step('0);
                front = sb.pop_front();
                exp_occ--;
                chk($sformatf("wrap_pop%0d_dout", i), dout, {192'd0, fp(front)});
                chk($sformatf("wrap_pop%0d_stat", i), 256'(stat_act()),
                    256'(stat_exp(3'(exp_occ), 0, 1, 0, 4'b0001)));
            end
        end
        for (int k = 0; k < DEP && sb.size() > 0; k++) begin
            step('0);
            front = sb.pop_front();
            exp_occ--;
            chk($sformatf("wrap_drain%0d_dout", k), dout, {192'd0, fp(front)});
            chk($sformatf("wrap_drain%0d_stat", k), 256'(stat_act()),
                256'(stat_exp(3'(exp_occ), 0, 1, 0, 4'b0001)));
        end
        chk("wrap_sb_empty", 256'(sb.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
